// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode.
// Holds {instruction, pc, branch_taken} entries; flush drops everything buffered.
module fetch_queue #(
    parameter int DEPTH            = 4,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int ADDR_SIZE        = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTRUCTION_SIZE-1:0]   in_instruction,
    input  logic [ADDR_SIZE-1:0]          in_pc,
    input  logic                          in_branch_taken,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTRUCTION_SIZE-1:0]   out_instruction,
    output logic [ADDR_SIZE-1:0]          out_pc,
    output logic                          out_branch_taken,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [INSTRUCTION_SIZE-1:0] r_instr [DEPTH];
    logic [ADDR_SIZE-1:0]        r_pc    [DEPTH];
    logic                        r_bt    [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_wr;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on occupancy, never on out_ready, so a full
    // queue refuses a push even when a pop occurs in the same cycle.
    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_wr      = w_push && !flush;
    assign count     = r_count;

    // Empty queue presents all-zero fields, which decode as a no-op.
    assign out_instruction  = out_valid ? r_instr[r_head] : '0;
    assign out_pc           = out_valid ? r_pc[r_head]    : '0;
    assign out_branch_taken = out_valid ? r_bt[r_head]    : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; its contents are meaningless outside head..tail.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_instr[r_tail] <= in_instruction;
            r_pc[r_tail]    <= in_pc;
            r_bt[r_tail]    <= in_branch_taken;
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and the decoder. Accepts fetched instructions with their PC and branch-prediction bit, stores them in a circular FIFO, and presents the oldest entry to the decoder (`instruction`, `branch_taken` inputs). Decouples I-cache latency from decode stalls and drops all buffered instructions on a pipeline flush (branch mispredict, ecall redirect).

## Interface
Parameters:
- `DEPTH`, 4: number of entries. Must be a power of two and at least 2.
- `INSTRUCTION_SIZE`, `` `INSTRUCTION_SIZE`` (32): instruction width.
- `ADDR_SIZE`, `` `DATA_SIZE`` (64): PC width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue clear.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  queue can accept an instruction.
- `in_instruction`  in  INSTRUCTION_SIZE  fetched instruction word.
- `in_pc`  in  ADDR_SIZE  PC of the fetched instruction.
- `in_branch_taken`  in  1  fetch-stage prediction for this instruction.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumes the head this cycle (low = decode stall).
- `out_instruction`  out  INSTRUCTION_SIZE  head instruction; 0 when empty.
- `out_pc`  out  ADDR_SIZE  head PC; 0 when empty.
- `out_branch_taken`  out  1  head prediction; 0 when empty.
- `count`  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage: DEPTH entries of {instruction, pc, branch_taken}. Head and tail pointers of width $clog2(DEPTH) wrap naturally modulo DEPTH. `count` is a separate register.
- Push: occurs when `in_valid && in_ready`. The entry is written at the tail, and tail advances.
- Pop: occurs when `out_valid && out_ready`. Head advances.
- `in_ready = (count != DEPTH)`. It does not depend on `out_ready`, so there is no combinational path from decode to fetch. When the queue is full, a push is refused even if a pop happens in the same cycle.
- `out_valid = (count != 0)`.
- `out_*` is driven combinationally from the head entry, gated to all-zero when empty. An all-zero instruction has opcode 0, which the decoder treats as a no-op.
- Simultaneous push and pop (not full, not empty): `count` is unchanged and both pointers advance.
- `flush` has priority over push and pop. When asserted, head, tail and `count` are set to 0, and any push or pop in that cycle is discarded. Entry contents are not cleared.
- `in_valid` with `in_ready` low: the input is ignored. Fetch must hold its data until it is accepted.
- `count` range is 0..DEPTH. Overflow and underflow are impossible by construction.

## Timing
- Reset (`rst_n` low, asynchronous): head = tail = `count` = 0. Outputs are `out_valid`=0, `out_instruction`=0, `out_pc`=0, `out_branch_taken`=0, `in_ready`=1. Storage contents are don't-care.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency: an instruction pushed at edge N appears on `out_*` after edge N and can be popped at edge N+1. There is no empty-queue bypass.
- Throughput: one push and one pop per cycle sustained. A full queue with continuous `out_ready` loses one fetch slot per full event.
- `in_ready` falls in the cycle after the DEPTH-th push and rises in the cycle after the pop that leaves DEPTH-1 entries.
- After `flush`, `out_valid`=0 in the next cycle and the first post-flush push is visible one cycle later.

## Test plan
- Reset then single push: push {0x00500093, pc 0x1000, bt 0} at cycle 1 -> `out_valid`=1 from cycle 2 with identical fields; `out_ready`=1 at cycle 2 -> `count` back to 0 and `out_instruction`=0 at cycle 3.
- Fill and stall: `out_ready`=0, push 5 instructions back-to-back with DEPTH=4 -> first 4 accepted, `in_ready`=0 and `count`=4 after the 4th; 5th held until a pop; pop order equals push order.
- Wrap-around: 10 pushes with simultaneous pops at a steady state of 2 entries -> pointers wrap at least twice; PC sequence 0x1000, 0x1004, … emerges unbroken and `count` stays 2.
- Flush priority: 3 entries, assert `flush` with `in_valid` and `out_ready` high -> next cycle `count`=0, `out_valid`=0, flushed push absent; next push appears correctly.
- Branch-bit propagation: push alternating `in_branch_taken` 1/0 with a BEQ instruction (0x00208063) -> `out_branch_taken` matches per entry.
- Async reset mid-stream: assert `rst_n` low between edges with 3 entries -> `out_valid`=0 and `count`=0 immediately, `in_ready`=1.
